// File: rtl/mp3_ser_tx.sv
// mp3_ser_tx - serial byte transmitter for an MP3 decoder data port.
//
// Accepts bytes over a valid/ready handshake into a one-byte holding register.
// Each byte is shifted out MSB first on a divided serial clock (mp3_clk).
// mp3_sync is high for the whole bit cell of bit 7.
// A new byte starts only while the synchronised decoder request is high.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active high
//   in_data   in   [7:0] byte to transmit
//   in_valid  in   in_data is valid
//   in_ready  out  holding register empty (registered)
//   mp3_req   in   decoder data request (asynchronous to clk)
//   mp3_clk   out  serial clock, decoder samples on its rising edge
//   mp3_sync  out  high during the bit-7 cell of every byte
//   mp3_dat   out  serial data, MSB first
//   busy      out  shifting, in the inter-byte gap, or holding register full
module mp3_ser_tx #(
    parameter int DIV_HALF    = 2,  // system clocks per half period of mp3_clk (>= 1)
    parameter int SYNC_STAGES = 2,  // synchroniser depth on mp3_req (>= 2)
    parameter int GAP         = 3   // idle clocks after the last falling edge (>= SYNC_STAGES+1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mp3_req,
    output logic       mp3_clk,
    output logic       mp3_sync,
    output logic       mp3_dat,
    output logic       busy
);

    localparam int PW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t                 state_reg,     state_next;
    logic [7:0]             hold_reg,      hold_next;
    logic                   hold_full_reg, hold_full_next;
    logic [7:0]             shift_reg,     shift_next;
    logic [2:0]             bit_reg,       bit_next;
    logic [PW-1:0]          phase_reg,     phase_next;
    logic [GW-1:0]          gap_reg,       gap_next;
    logic                   clk_reg,       clk_next;
    logic                   sync_reg,      sync_next;
    logic                   dat_reg,       dat_next;
    logic [SYNC_STAGES-1:0] req_sync_reg;
    logic                   req_s;
    logic [2:0]             bit_dec;

    // mp3_req is asynchronous; only the synchronised copy is used below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync_reg <= '0;
        end else begin
            req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], mp3_req};
        end
    end

    assign req_s   = req_sync_reg[SYNC_STAGES-1];
    assign bit_dec = bit_reg - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            bit_reg       <= '0;
            phase_reg     <= '0;
            gap_reg       <= '0;
            clk_reg       <= 1'b0;
            sync_reg      <= 1'b0;
            dat_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            bit_reg       <= bit_next;
            phase_reg     <= phase_next;
            gap_reg       <= gap_next;
            clk_reg       <= clk_next;
            sync_reg      <= sync_next;
            dat_reg       <= dat_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shift_next     = shift_reg;
        bit_next       = bit_reg;
        phase_next     = phase_reg;
        gap_next       = gap_reg;
        clk_next       = clk_reg;
        sync_next      = sync_reg;
        dat_next       = dat_reg;

        // Load only into an empty holding register. The IDLE transfer below
        // needs a full one, so the two can never collide in one cycle.
        if (in_valid && !hold_full_reg) begin
            hold_next      = in_data;
            hold_full_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                clk_next  = 1'b0;
                sync_next = 1'b0;
                if (hold_full_reg && req_s) begin
                    shift_next     = hold_reg;
                    hold_full_next = 1'b0;
                    bit_next       = 3'd7;
                    phase_next     = '0;
                    // First cell's data and sync are presented together with
                    // the low phase, giving DIV_HALF clocks of setup.
                    dat_next       = hold_reg[7];
                    sync_next      = 1'b1;
                    state_next     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (phase_reg == PHASE_LAST) begin
                    phase_next = '0;
                    if (!clk_reg) begin
                        clk_next = 1'b1;
                    end else begin
                        // Falling edge: data and sync only ever change here.
                        clk_next  = 1'b0;
                        sync_next = 1'b0;
                        if (bit_reg == 3'd0) begin
                            gap_next   = '0;
                            state_next = ST_GAP;
                        end else begin
                            bit_next = bit_dec;
                            dat_next = shift_reg[bit_dec];
                        end
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end

            ST_GAP: begin
                // Long enough for the decoder to drop req after the last
                // falling edge and for that to reach req_s.
                clk_next = 1'b0;
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready = ~hold_full_reg;
    assign busy     = (state_reg != ST_IDLE) || hold_full_reg;
    assign mp3_clk  = clk_reg;
    assign mp3_sync = sync_reg;
    assign mp3_dat  = dat_reg;

endmodule

// File: tb/tb_mp3_ser_tx.sv
// tb_mp3_ser_tx - self-checking bench for mp3_ser_tx.
// A receiver model samples mp3_dat on each mp3_clk rising edge and compares
// assembled bytes against a scoreboard queue filled when bytes are accepted.
// A second instance with DIV_HALF=1 covers the fastest serial clock.
`timescale 1ns/1ps
module tb_mp3_ser_tx;

    localparam int DH      = 2;
    localparam int SS      = 2;
    localparam int GP      = 3;
    localparam int SPACING = 16*DH + GP + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mp3_req;
    logic       mp3_clk;
    logic       mp3_sync;
    logic       mp3_dat;
    logic       busy;

    logic [7:0] d1_in_data;
    logic       d1_in_valid;
    logic       d1_in_ready;
    logic       d1_req;
    logic       d1_clk;
    logic       d1_sync;
    logic       d1_dat;
    logic       d1_busy;

    always #5 clk = ~clk;

    mp3_ser_tx #(.DIV_HALF(DH), .SYNC_STAGES(SS), .GAP(GP)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mp3_req  (mp3_req),
        .mp3_clk  (mp3_clk),
        .mp3_sync (mp3_sync),
        .mp3_dat  (mp3_dat),
        .busy     (busy)
    );

    mp3_ser_tx #(.DIV_HALF(1), .SYNC_STAGES(SS), .GAP(GP)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (d1_in_data),
        .in_valid (d1_in_valid),
        .in_ready (d1_in_ready),
        .mp3_req  (d1_req),
        .mp3_clk  (d1_clk),
        .mp3_sync (d1_sync),
        .mp3_dat  (d1_dat),
        .busy     (d1_busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];
    int         sync_q[$];
    int         cyc        = 0;
    int         bytes_rx   = 0;
    int         rise_total = 0;
    int         sync_total = 0;
    int         rx_cnt     = 0;
    logic [7:0] rx_shift   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a byte; exp_ready is the in_ready value expected at the moment of offer.
    task automatic send(input logic [7:0] b, input logic exp_ready);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        check("ready_at_offer", 32'(in_ready), 32'(exp_ready));
        while (!in_ready && n < 400) begin
            step();
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%02h not accepted, expected acceptance", b);
        end else begin
            sb_q.push_back(b);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target, input string name);
        int n;
        n = 0;
        while (bytes_rx < target && n < 1000) begin
            step();
            n++;
        end
        check(name, 32'(bytes_rx), 32'(target));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(busy), 32'(0));
    endtask

    // Receiver model / protocol monitor for the DIV_HALF=2 instance.
    initial begin
        logic       prev_clk;
        logic       prev_sync;
        int         last_rise;
        int         sync_len;
        logic [7:0] exp_b;
        prev_clk  = 1'b0;
        prev_sync = 1'b0;
        last_rise = 0;
        sync_len  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rx_cnt    = 0;
                prev_clk  = 1'b0;
                prev_sync = 1'b0;
                sync_len  = 0;
            end else begin
                if (mp3_clk && !prev_clk) begin
                    rise_total++;
                    if (rx_cnt > 0) check("bit_period", 32'(cyc - last_rise), 32'(2*DH));
                    check("sync_on_bit7", 32'(mp3_sync), 32'(rx_cnt == 0));
                    last_rise = cyc;
                    rx_shift  = {rx_shift[6:0], mp3_dat};
                    rx_cnt++;
                    if (rx_cnt == 8) begin
                        rx_cnt = 0;
                        bytes_rx++;
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL rx_unexpected: got byte 0x%02h, expected no byte", rx_shift);
                        end else begin
                            exp_b = sb_q.pop_front();
                            $display("rx byte 0x%02h (expected 0x%02h) at cycle %0d", rx_shift, exp_b, cyc);
                            check("rx_byte", 32'(rx_shift), 32'(exp_b));
                        end
                    end
                end
                if (mp3_sync) sync_len++;
                if (mp3_sync && !prev_sync) begin
                    sync_total++;
                    sync_q.push_back(cyc);
                    check("start_with_req", 32'(mp3_req), 32'(1));
                end
                if (!mp3_sync && prev_sync) begin
                    check("sync_len", 32'(sync_len), 32'(2*DH));
                    sync_len = 0;
                end
                prev_clk  = mp3_clk;
                prev_sync = mp3_sync;
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
        int         exp_spacing;
    } vec_t;

    initial begin
        vec_t       vecs[3];
        int         base;
        int         r0;
        int         s0;
        int         n;
        int         highs;
        int         rises;
        int         last;
        logic       pc;
        logic       pd;
        logic [7:0] val;

        vecs[0] = '{8'h00, 1'b1, 0};
        vecs[1] = '{8'hFF, 1'b0, SPACING};
        vecs[2] = '{8'h3C, 1'b0, SPACING};

        rst         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        mp3_req     = 1'b1;
        d1_in_data  = 8'h00;
        d1_in_valid = 1'b0;
        d1_req      = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_clk",      32'(mp3_clk),  32'(0));
        check("rst_sync",     32'(mp3_sync), 32'(0));
        check("rst_dat",      32'(mp3_dat),  32'(0));
        check("rst_d1_ready", 32'(d1_in_ready), 32'(1));
        rst = 1'b0;
        repeat (4) step();

        // Test 1: single byte 0xA5
        base = bytes_rx;
        r0   = rise_total;
        send(8'hA5, 1'b1);
        check("t1_ready_after_load", 32'(in_ready), 32'(0));
        check("t1_busy_after_load",  32'(busy),     32'(1));
        check("t1_sync_before",      32'(mp3_sync), 32'(0));
        step();
        check("t1_sync_start",       32'(mp3_sync), 32'(1));
        check("t1_ready_at_start",   32'(in_ready), 32'(1));
        check("t1_dat_first",        32'(mp3_dat),  32'(1));
        wait_rx(base + 1, "t1_rx_done");
        wait_idle("t1_idle");
        check("t1_rise_count", 32'(rise_total - r0), 32'(8));

        // Test 2: streamed bytes, table-driven
        repeat (3) step();
        sync_q.delete();
        base = bytes_rx;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].data, vecs[i].exp_ready);
        end
        wait_rx(base + 3, "t2_rx_done");
        wait_idle("t2_idle");
        check("t2_sync_count", 32'(sync_q.size()), 32'(3));
        for (int i = 1; i < 3; i++) begin
            if (sync_q.size() > i) check("t2_sync_spacing", 32'(sync_q[i] - sync_q[i-1]), 32'(vecs[i].exp_spacing));
        end

        // Test 3: decoder drops req after bit 0 with a byte waiting
        repeat (3) step();
        base = bytes_rx;
        send(8'h5A, 1'b1);
        send(8'hC3, 1'b0);
        wait_rx(base + 1, "t3_first_rx");
        n = 0;
        while (mp3_clk && n < 20) begin
            step();
            n++;
        end
        mp3_req = 1'b0;
        repeat (40) begin
            step();
            check("t3_no_sync", 32'(mp3_sync), 32'(0));
        end
        check("t3_hold_kept", 32'(in_ready), 32'(0));
        check("t3_busy",      32'(busy),     32'(1));
        mp3_req = 1'b1;
        n = 0;
        while (!mp3_sync && n < SS + 2) begin
            step();
            n++;
        end
        check("t3_resume", 32'(mp3_sync), 32'(1));
        wait_rx(base + 2, "t3_second_rx");
        wait_idle("t3_idle");

        // Test 4: reset during bit 4 of 0x81 with a byte in hold
        repeat (3) step();
        send(8'h81, 1'b1);
        send(8'h7E, 1'b0);
        n = 0;
        while (!(rx_cnt == 4 && mp3_clk) && n < 200) begin
            step();
            n++;
        end
        check("t4_mid_byte_clk", 32'(mp3_clk), 32'(1));
        rst = 1'b1;
        #1;
        check("t4_rst_clk",   32'(mp3_clk),  32'(0));
        check("t4_rst_sync",  32'(mp3_sync), 32'(0));
        check("t4_rst_dat",   32'(mp3_dat),  32'(0));
        check("t4_rst_ready", 32'(in_ready), 32'(1));
        check("t4_rst_busy",  32'(busy),     32'(0));
        sb_q.delete();
        repeat (2) step();
        rst = 1'b0;
        s0  = sync_total;
        repeat (60) step();
        check("t4_no_tx_after_rst", 32'(sync_total - s0), 32'(0));
        check("t4_idle_busy",       32'(busy),     32'(0));
        check("t4_idle_ready",      32'(in_ready), 32'(1));
        base = bytes_rx;
        send(8'hE7, 1'b1);
        wait_rx(base + 1, "t4_new_rx");
        wait_idle("t4_idle");

        // Test 5: DIV_HALF=1 instance, byte 0x96
        d1_in_data  = 8'h96;
        d1_in_valid = 1'b1;
        n = 0;
        while (!d1_in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        d1_in_valid = 1'b0;
        rises = 0;
        last  = 0;
        val   = 8'h00;
        pc    = d1_clk;
        pd    = d1_dat;
        n     = 0;
        while (rises < 8 && n < 100) begin
            step();
            n++;
            if (pc && rises > 0) check("t5_clk_falls", 32'(d1_clk), 32'(0));
            if (d1_clk && !pc) begin
                check("t5_setup_stable", 32'(d1_dat), 32'(pd));
                if (rises > 0) check("t5_rise_spacing", 32'(n - last), 32'(2));
                check("t5_sync", 32'(d1_sync), 32'(rises == 0));
                val   = {val[6:0], d1_dat};
                rises = rises + 1;
                last  = n;
            end
            pc = d1_clk;
            pd = d1_dat;
        end
        $display("d1 rx byte 0x%02h (expected 0x96)", val);
        check("t5_rises", 32'(rises), 32'(8));
        check("t5_byte",  32'(val),   32'(8'h96));
        repeat (10) step();
        check("t5_d1_idle", 32'(d1_busy), 32'(0));

        // Test 6: req low from reset, byte waits
        mp3_req = 1'b0;
        rst     = 1'b1;
        sb_q.delete();
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        base = bytes_rx;
        send(8'h55, 1'b1);
        check("t6_ready_after_load", 32'(in_ready), 32'(0));
        check("t6_busy_after_load",  32'(busy),     32'(1));
        highs = 0;
        repeat (30) begin
            step();
            if (mp3_clk) highs++;
        end
        check("t6_clk_idle", 32'(highs),    32'(0));
        check("t6_hold",     32'(in_ready), 32'(0));
        check("t6_busy",     32'(busy),     32'(1));
        mp3_req = 1'b1;
        wait_rx(base + 1, "t6_rx");
        wait_idle("t6_idle");

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
